// File: rtl/mult_share_arbiter_pkg.sv
// Shared types and widths for the shared-multiplier arbiter.
package mult_pkg;

   localparam int OP_W   = 4;
   localparam int PROD_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Requester/result bundle between client blocks and the shared multiplier arbiter.
interface mult_share_arbiter_if
   import mult_pkg::*;
#(
   parameter int N_REQ = 4
);
   localparam int ID_W = id_width(N_REQ);

   logic [N_REQ-1:0]      req_valid;
   logic [N_REQ-1:0]      req_ready;
   logic [OP_W*N_REQ-1:0] req_a;
   logic [OP_W*N_REQ-1:0] req_b;
   logic                  res_valid;
   logic                  res_ready;
   logic [PROD_W-1:0]     res_p;
   logic [ID_W-1:0]       res_id;
   logic                  busy;

   modport master (
      output req_valid, req_a, req_b, res_ready,
      input  req_ready, res_valid, res_p, res_id, busy
   );

   modport slave (
      input  req_valid, req_a, req_b, res_ready,
      output req_ready, res_valid, res_p, res_id, busy
   );

endinterface

// File: rtl/mult_share_arbiter_mult.sv
// Combinational unsigned 4x4 array multiplier: one ripple row per multiplier bit.
module multiplier_4bit
   import mult_pkg::*;
(
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   output logic [PROD_W-1:0] p
);

   logic [OP_W-1:0] pp  [OP_W];
   logic [OP_W:0]   row [OP_W];

   always_comb begin
      // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
      for (int i = 0; i < OP_W; i++) begin
         pp[i] = a & {OP_W{b[i]}};
      end
   end

   assign row[0] = {1'b0, pp[0]};
   assign p[0]   = row[0][0];

   // Each row adds the next partial product to the previous row's upper bits;
   // the row's LSB is final and drops out as one product bit.
   for (genvar i = 1; i < OP_W; i++) begin : g_row
      assign row[i] = {1'b0, row[i-1][OP_W:1]} + {1'b0, pp[i]};
      assign p[i]   = row[i][0];
   end

   assign p[PROD_W-1:OP_W] = row[OP_W-1][OP_W:1];

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one 4x4 multiplier among N_REQ requesters.
module mult_share_arbiter
   import mult_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   mult_share_arbiter_if.slave bus
);

   localparam int ID_W = id_width(N_REQ);

   state_t            state;
   logic              busy;
   logic              res_valid;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   id;
   logic [ID_W-1:0]   res_id;
   logic [OP_W-1:0]   op_a;
   logic [OP_W-1:0]   op_b;
   logic [PROD_W-1:0] res_p;
   logic [PROD_W-1:0] prod;

   logic              grant_any;
   logic [ID_W-1:0]   winner;
   logic [ID_W-1:0]   next_ptr;
   logic [OP_W-1:0]   sel_a;
   logic [OP_W-1:0]   sel_b;
   logic [N_REQ-1:0]  ready;

   // Scan from ptr upward with wrap; iterating downward lets the lowest offset win.
   function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] valid,
                                             input logic [ID_W-1:0]  ptr);
      logic [ID_W:0]   pick;
      logic [ID_W-1:0] idx;
      pick = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = ID_W'((int'(ptr) + k) % N_REQ);
         if (valid[idx]) pick = {1'b1, idx};
      end
      return pick;
   endfunction

   always_comb begin
      {grant_any, winner} = rr_pick(bus.req_valid, rr_ptr);
      next_ptr = ID_W'((int'(winner) + 1) % N_REQ);
      sel_a    = OP_W'(bus.req_a >> (OP_W * int'(winner)));
      sel_b    = OP_W'(bus.req_b >> (OP_W * int'(winner)));
      ready    = '0;
      if (state == IDLE && grant_any) ready[winner] = 1'b1;
   end

   multiplier_4bit u_mult (
      .a (op_a),
      .b (op_b),
      .p (prod)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         rr_ptr    <= '0;
         id        <= '0;
         op_a      <= '0;
         op_b      <= '0;
         res_p     <= '0;
         res_id    <= '0;
         res_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  op_a   <= sel_a;
                  op_b   <= sel_b;
                  id     <= winner;
                  rr_ptr <= next_ptr;
                  busy   <= 1'b1;
                  state  <= CALC;
               end
            end
            CALC: begin
               res_p     <= prod;
               res_id    <= id;
               res_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               // Result is held until downstream takes it.
               if (res_valid && bus.res_ready) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               res_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready = ready;
   assign bus.res_valid = res_valid;
   assign bus.res_p     = res_p;
   assign bus.res_id    = res_id;
   assign bus.busy      = busy;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scenario tests plus randomized traffic against a transaction-level model of the arbiter.
module tb_mult_share_arbiter;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   mult_share_arbiter_if #(.N_REQ(N)) bus ();

   mult_share_arbiter #(.N_REQ(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic set_req(input int i, input logic v, input logic [3:0] a, input logic [3:0] b);
      bus.req_valid[i]     = v;
      bus.req_a[4*i +: 4]  = a;
      bus.req_b[4*i +: 4]  = b;
   endtask

   task automatic reset_dut();
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.res_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic cmp(input string name, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Wait (bounded) at negedges until a grant is visible; returns the observed vector.
   task automatic wait_grant(input string name, output logic [N-1:0] g);
      int c = 0;
      #1;
      while (bus.req_ready == '0 && c < 20) begin
         @(negedge clk);
         #1;
         c++;
      end
      g = bus.req_ready;
      if (c >= 20) begin
         total++;
         bad++;
         $display("FAIL %s: no grant within 20 cycles", name);
      end
   endtask

   task automatic wait_result(input string name);
      int c = 0;
      while (bus.res_valid !== 1'b1 && c < 20) begin
         @(negedge clk);
         c++;
      end
      if (c >= 20) begin
         total++;
         bad++;
         $display("FAIL %s: no result within 20 cycles", name);
      end
   endtask

   task automatic test_reset();
      reset_dut();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.req_ready !== '0 || bus.res_valid !== 1'b0 || bus.busy !== 1'b0 ||
             bus.res_p !== 8'd0 || bus.res_id !== 2'd0) begin
            bad++;
            $display("FAIL reset_idle: cycle %0d ready=%b res_valid=%b busy=%b p=%0d id=%0d",
                     c, bus.req_ready, bus.res_valid, bus.busy, bus.res_p, bus.res_id);
         end
         total++;
      end
   endtask

   task automatic test_single();
      reset_dut();
      bus.res_ready = 1'b1;
      set_req(0, 1'b1, 4'd3, 4'd5);
      #1;
      cmp("single_grant", int'(bus.req_ready), 1);
      @(posedge clk);
      #1;
      set_req(0, 1'b0, 4'd0, 4'd0);
      @(negedge clk);
      cmp("single_calc_ready", int'(bus.req_ready), 0);
      cmp("single_calc_valid", int'(bus.res_valid), 0);
      cmp("single_calc_busy", int'(bus.busy), 1);
      @(negedge clk);
      cmp("single_done_valid", int'(bus.res_valid), 1);
      cmp("single_p", int'(bus.res_p), 15);
      cmp("single_id", int'(bus.res_id), 0);
      @(negedge clk);
      cmp("single_idle_busy", int'(bus.busy), 0);
      cmp("single_idle_valid", int'(bus.res_valid), 0);
   endtask

   task automatic test_round_robin();
      logic [N-1:0] g;
      int exp;
      reset_dut();
      bus.res_ready = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 4'(i + 1), 4'd2);
      for (int n = 0; n < 5; n++) begin
         exp = n % N;
         wait_grant("rr_grant_wait", g);
         cmp("rr_grant", int'(g), 1 << exp);
         @(negedge clk);
         wait_result("rr_result_wait");
         cmp("rr_p", int'(bus.res_p), (exp + 1) * 2);
         cmp("rr_id", int'(bus.res_id), exp);
         @(negedge clk);
      end
      bus.req_valid = '0;
   endtask

   task automatic test_backpressure();
      logic [N-1:0] g;
      reset_dut();
      bus.res_ready = 1'b0;
      set_req(0, 1'b1, 4'd15, 4'd15);
      set_req(1, 1'b1, 4'd7, 4'd9);
      wait_grant("bp_grant_wait", g);
      cmp("bp_grant", int'(g), 1);
      @(posedge clk);
      #1;
      set_req(0, 1'b0, 4'd0, 4'd0);
      @(negedge clk);
      wait_result("bp_result_wait");
      for (int c = 0; c < 5; c++) begin
         cmp("bp_hold_valid", int'(bus.res_valid), 1);
         cmp("bp_hold_p", int'(bus.res_p), 225);
         cmp("bp_hold_id", int'(bus.res_id), 0);
         cmp("bp_hold_ready", int'(bus.req_ready), 0);
         @(negedge clk);
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      cmp("bp_release_valid", int'(bus.res_valid), 0);
      cmp("bp_next_grant", int'(bus.req_ready), 2);
      @(posedge clk);
      #1;
      set_req(1, 1'b0, 4'd0, 4'd0);
      @(negedge clk);
      wait_result("bp_second_wait");
      cmp("bp_second_p", int'(bus.res_p), 63);
      cmp("bp_second_id", int'(bus.res_id), 1);
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [N-1:0] g;
      reset_dut();
      bus.res_ready = 1'b1;
      set_req(2, 1'b1, 4'd11, 4'd13);
      wait_grant("mid_grant_wait", g);
      cmp("mid_grant", int'(g), 4);
      @(posedge clk);
      #1;
      set_req(2, 1'b0, 4'd0, 4'd0);
      @(negedge clk);
      cmp("mid_calc_busy", int'(bus.busy), 1);
      rst_n = 1'b0;
      #1;
      cmp("mid_rst_busy", int'(bus.busy), 0);
      cmp("mid_rst_valid", int'(bus.res_valid), 0);
      cmp("mid_rst_p", int'(bus.res_p), 0);
      cmp("mid_rst_id", int'(bus.res_id), 0);
      cmp("mid_rst_ready", int'(bus.req_ready), 0);
      @(negedge clk);
      cmp("mid_rst_no_result", int'(bus.res_valid), 0);
      set_req(1, 1'b1, 4'd4, 4'd6);
      set_req(3, 1'b1, 4'd9, 4'd9);
      rst_n = 1'b1;
      #1;
      cmp("mid_after_grant", int'(bus.req_ready), 2);
      @(posedge clk);
      #1;
      set_req(1, 1'b0, 4'd0, 4'd0);
      set_req(3, 1'b0, 4'd0, 4'd0);
      @(negedge clk);
      wait_result("mid_result_wait");
      cmp("mid_after_p", int'(bus.res_p), 24);
      cmp("mid_after_id", int'(bus.res_id), 1);
      @(negedge clk);
   endtask

   // Transaction model: a single product may be outstanding; while none is,
   // the winner is the first pending requester at or after the pointer.
   task automatic test_random();
      logic [N-1:0] va = '0;
      int ra [N];
      int rb [N];
      int granted [N];
      int accepted [N];
      int ptr = 0;
      int outstanding = 0;
      int age = 0;
      int exp_p = 0;
      int exp_id = 0;
      int results = 0;
      int cycles = 0;
      int w;
      int g = -1;
      int idx;
      logic [N-1:0] exp_ready;
      for (int i = 0; i < N; i++) begin
         ra[i] = 0; rb[i] = 0; granted[i] = 0; accepted[i] = 0;
      end
      reset_dut();
      while (results < 2000 && cycles < 40000) begin
         // sample half a cycle after the inputs were driven
         w = -1;
         if (outstanding == 0) begin
            for (int k = 0; k < N; k++) begin
               idx = (ptr + k) % N;
               if (w < 0 && va[idx]) w = idx;
            end
         end
         exp_ready = (w >= 0) ? N'(1 << w) : '0;
         cmp("rand_ready", int'(bus.req_ready), int'(exp_ready));
         cmp("rand_busy", int'(bus.busy), outstanding);
         cmp("rand_res_valid", int'(bus.res_valid), (outstanding == 1 && age >= 1) ? 1 : 0);
         if (outstanding == 1 && age >= 1) begin
            cmp("rand_p", int'(bus.res_p), exp_p);
            cmp("rand_id", int'(bus.res_id), exp_id);
            if (bus.res_ready) begin
               accepted[exp_id]++;
               results++;
               outstanding = 0;
            end
         end else if (outstanding == 1) begin
            age = 1;
         end else if (w >= 0) begin
            exp_p  = ra[w] * rb[w];
            exp_id = w;
            ptr    = (w + 1) % N;
            granted[w]++;
            outstanding = 1;
            age = 0;
            g = w;
         end
         @(posedge clk);
         #1;
         if (g >= 0) begin
            va[g] = 1'b0;
            g = -1;
         end
         for (int i = 0; i < N; i++) begin
            if (!va[i]) begin
               if ($urandom % 3 == 0) begin
                  va[i] = 1'b1;
                  ra[i] = int'($urandom % 16);
                  rb[i] = int'($urandom % 16);
               end
            end else if ($urandom % 32 == 0) begin
               va[i] = 1'b0;
            end
            set_req(i, va[i], 4'(ra[i]), 4'(rb[i]));
         end
         bus.res_ready = ($urandom % 3 != 0);
         @(negedge clk);
         cycles++;
      end
      cmp("rand_result_count", results, 2000);
      for (int i = 0; i < N; i++) begin
         if (granted[i] - accepted[i] > outstanding) begin
            total++;
            bad++;
            $display("FAIL rand_per_id: id %0d granted %0d accepted %0d", i, granted[i], accepted[i]);
         end else begin
            total++;
         end
      end
      bus.req_valid = '0;
      bus.res_ready = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
